alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL provide port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide port: instr_valid  in  1  data-processing instruction offered.
REQ-004 SHALL provide port: instr_ready  out  1  controller can accept; transfer when instr_valid & instr_ready.
REQ-005 SHALL provide port: instr  in  32  cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], imm8[7:0], Rm[3:0].
REQ-006 SHALL provide port: rf_raddr  out  4  register-file read address; rf_rdata is valid in the same cycle.
REQ-007 SHALL provide port: rf_rdata  in  32  register-file read data.
REQ-008 SHALL provide ports: alu_codes  out  3 (3'b001 immediate, 3'b000 register); alu_opcode  out  4; alu_r1, alu_r2, alu_op2  out  32 each; alu_data  in  33.
REQ-009 SHALL provide ports: rf_we  out  1; rf_waddr  out  4; rf_wdata  out  32.
REQ-010 SHALL provide ports: nzcv  out  4  flags register; done  out  1  one-cycle completion pulse; illegal  out  1  valid with done.

Function
REQ-011 SHALL implement FSM states IDLE, COND, RD_RN, RD_RM, EXEC, WB.
REQ-012 SHALL assert instr_ready only in IDLE; on accept, latch instr and move to COND.
REQ-013 COND SHALL evaluate cond against nzcv: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE per ARM semantics, AL true, 4'b1111 false.
REQ-014 On condition fail, COND SHALL go to IDLE and pulse done with no write and no flag change (2 cycles, accept to done).
REQ-015 On pass, a supported opcode SHALL go to RD_RN. Supported opcodes: 0000, 0001, 0010, 0100, 1000, 1001, 1010, 1100, 1101, 1110, 1111.
REQ-016 An unsupported opcode SHALL return to IDLE with done=1 and illegal=1, and no other effect.
REQ-017 RD_RN SHALL drive rf_raddr=Rn and latch rf_rdata as A; next state is RD_RM if I=0, else EXEC.
REQ-018 RD_RM SHALL drive rf_raddr=Rm, latch rf_rdata as B, then go to EXEC.
REQ-019 EXEC SHALL drive alu_opcode=opcode and set alu_codes per I.
REQ-020 For I=1, EXEC SHALL drive alu_r2=A and alu_op2={24'b0,imm8}; for I=0, alu_r1=A and alu_r2=B. Unused ALU inputs SHALL be 0.
REQ-021 EXEC SHALL register alu_data[31:0] as result and alu_data[32] as carry.
REQ-022 Flag update, applied at end of EXEC, SHALL occur only if S=1 or opcode is 1000/1001/1010.
REQ-023 Flag values: N=result[31]; Z=(result==0).
REQ-024 For 0010/0100/1010, C=carry and V is signed overflow of the 32-bit operands. For all other opcodes, C and V SHALL hold their value.
REQ-025 WB SHALL pulse rf_we for one cycle with rf_waddr=Rd and rf_wdata=result, except for opcodes 1000/1001/1010, which write nothing.
REQ-026 WB SHALL pulse done and return to IDLE.
REQ-027 Latency from accept to done SHALL be 5 cycles for register form and 4 cycles for immediate form.
REQ-028 A new instruction SHALL be accepted no earlier than the cycle after done.
REQ-029 rf_we, done and illegal SHALL never be asserted outside WB/COND as specified.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, nzcv=0, rf_we=0, done=0, illegal=0, all latched operands and outputs to 0; instr_ready=1 after release.
REQ-031 Reset mid-instruction SHALL abort it with no register write and no flag update.

Structure
REQ-032 A shared package cpu_pkg SHALL hold the FSM state enum, the 4-bit opcode constants, the 4-bit condition constants and the alu_codes constants.
REQ-033 Condition evaluation SHALL be a combinational sub-module cond_check (in: cond, nzcv; out: pass).

Verification
REQ-034 Bench SHALL cover: R1=5, R2=3, ADDS R0,R1,R2 (cond AL) -> R0=8, nzcv=0000, done 5 cycles after accept.
REQ-035 Bench SHALL cover: R1=3, CMP R1,#3 -> no rf_we, nzcv=0110 (Z=1, C=1), done at cycle 4.
REQ-036 Bench SHALL cover: after REQ-035, MOVNE R4,#7 -> condition fails, no write, done at cycle 2; then MOVEQ R4,#7 -> R4=7.
REQ-037 Bench SHALL cover: R1=0x7FFFFFFF, ADDS R0,R1,#1 -> R0=0x80000000, nzcv=1001.
REQ-038 Bench SHALL cover: opcode 0011 -> done=1, illegal=1, no write, nzcv unchanged.
REQ-039 Bench SHALL cover: rst_n asserted during EXEC of ADDS -> no rf_we, nzcv=0000, instr_ready=1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the data-processing execute controller.
// FSM states, ARM opcode/condition encodings and ALU operand-form codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COND  = 3'd1,
        ST_RD_RN = 3'd2,
        ST_RD_RM = 3'd3,
        ST_EXEC  = 3'd4,
        ST_WB    = 3'd5
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [2:0] ALU_CODES_REG = 3'b000;
    localparam logic [2:0] ALU_CODES_IMM = 3'b001;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            OP_AND, OP_EOR, OP_SUB, OP_ADD,
            OP_TST, OP_TEQ, OP_CMP, OP_ORR,
            OP_MOV, OP_BIC, OP_MVN: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Compare-class ops set flags unconditionally and never write Rd.
    function automatic logic op_compare(input logic [3:0] op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP);
    endfunction

    function automatic logic op_arith(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_ADD) || (op == OP_CMP);
    endfunction

    function automatic logic op_is_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the current NZCV flags.
// Purely combinational; NV (4'b1111) never passes.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle controller sequencing one data-processing instruction:
// condition check, operand reads, ALU execute, flag update and write-back.
module alu_exec_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [2:0]  alu_codes,
    output logic [3:0]  alu_opcode,
    output logic [31:0] alu_r1,
    output logic [31:0] alu_r2,
    output logic [31:0] alu_op2,
    input  logic [32:0] alu_data,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  nzcv,
    output logic        done,
    output logic        illegal
);

    state_t      state;
    logic [31:0] ir;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;

    logic [3:0]  cond;
    logic        imm_f;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [7:0]  imm8;
    logic [3:0]  rm;
    logic        unused_ir;

    assign cond   = ir[31:28];
    assign imm_f  = ir[25];
    assign opcode = ir[24:21];
    assign s_bit  = ir[20];
    assign rn     = ir[19:16];
    assign rd     = ir[15:12];
    assign imm8   = ir[7:0];
    assign rm     = ir[3:0];

    assign unused_ir = ^{ir[27:26], ir[11:8]};

    logic cond_pass;

    cond_check u_cond (
        .cond (cond),
        .nzcv (nzcv),
        .pass (cond_pass)
    );

    // done blocks the accept so a new instruction lands the cycle after it.
    assign instr_ready = (state == ST_IDLE) && !done;
    assign rf_waddr    = rd;
    assign rf_wdata    = result;

    always_comb begin
        rf_raddr = 4'd0;
        case (state)
            ST_RD_RN: rf_raddr = rn;
            ST_RD_RM: rf_raddr = rm;
            default:  rf_raddr = 4'd0;
        endcase
    end

    always_comb begin
        alu_codes  = ALU_CODES_REG;
        alu_opcode = 4'd0;
        alu_r1     = 32'd0;
        alu_r2     = 32'd0;
        alu_op2    = 32'd0;
        if (state == ST_EXEC) begin
            alu_opcode = opcode;
            if (imm_f) begin
                alu_codes = ALU_CODES_IMM;
                alu_r2    = op_a;
                alu_op2   = {24'd0, imm8};
            end else begin
                alu_codes = ALU_CODES_REG;
                alu_r1    = op_a;
                alu_r2    = op_b;
            end
        end
    end

    logic [31:0] opnd_b;
    logic [31:0] res_next;
    logic        ovf;
    logic        arith;
    logic        flag_upd;
    logic [3:0]  nzcv_next;

    assign opnd_b   = imm_f ? {24'd0, imm8} : op_b;
    assign res_next = alu_data[31:0];
    assign arith    = op_arith(opcode);
    assign flag_upd = s_bit || op_compare(opcode);

    // Signed overflow judged on the operands as the ALU saw them.
    always_comb begin
        if (op_is_sub(opcode))
            ovf = (op_a[31] != opnd_b[31]) && (res_next[31] != op_a[31]);
        else
            ovf = (op_a[31] == opnd_b[31]) && (res_next[31] != op_a[31]);
    end

    assign nzcv_next = {
        res_next[31],
        (res_next == 32'd0),
        arith ? alu_data[32] : nzcv[1],
        arith ? ovf          : nzcv[0]
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ir      <= 32'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            result  <= 32'd0;
            nzcv    <= 4'd0;
            rf_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        ir    <= instr;
                        state <= ST_COND;
                    end
                end
                ST_COND: begin
                    if (!cond_pass) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (!op_supported(opcode)) begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        state <= ST_RD_RN;
                    end
                end
                ST_RD_RN: begin
                    op_a  <= rf_rdata;
                    state <= imm_f ? ST_EXEC : ST_RD_RM;
                end
                ST_RD_RM: begin
                    op_b  <= rf_rdata;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    result <= res_next;
                    if (flag_upd)
                        nzcv <= nzcv_next;
                    rf_we <= !op_compare(opcode);
                    done  <= 1'b1;
                    state <= ST_WB;
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural register file and ALU.
// Table-driven instruction vectors plus reset and abort sequences.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [2:0]  alu_codes;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic [31:0] alu_op2;
    logic [32:0] alu_data;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  nzcv;
    logic        done;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .alu_codes   (alu_codes),
        .alu_opcode  (alu_opcode),
        .alu_r1      (alu_r1),
        .alu_r2      (alu_r2),
        .alu_op2     (alu_op2),
        .alu_data    (alu_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .nzcv        (nzcv),
        .done        (done),
        .illegal     (illegal)
    );

    logic [31:0] rf [16];
    logic        tb_wr = 1'b0;
    logic [3:0]  tb_waddr = 4'd0;
    logic [31:0] tb_wval = 32'd0;

    assign rf_rdata = rf[rf_raddr];

    always @(posedge clk) begin
        if (tb_wr)
            rf[tb_waddr] <= tb_wval;
        else if (rf_we)
            rf[rf_waddr] <= rf_wdata;
    end

    // Reference ALU: immediate form uses r2/op2, register form r1/r2.
    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        a = (alu_codes == 3'b001) ? alu_r2 : alu_r1;
        b = (alu_codes == 3'b001) ? alu_op2 : alu_r2;
        case (alu_opcode)
            4'b0000: alu_data = {1'b0, a & b};
            4'b0001: alu_data = {1'b0, a ^ b};
            4'b0010: alu_data = {1'b0, a} + {1'b0, ~b} + 33'd1;
            4'b0100: alu_data = {1'b0, a} + {1'b0, b};
            4'b1000: alu_data = {1'b0, a & b};
            4'b1001: alu_data = {1'b0, a ^ b};
            4'b1010: alu_data = {1'b0, a} + {1'b0, ~b} + 33'd1;
            4'b1100: alu_data = {1'b0, a | b};
            4'b1101: alu_data = {1'b0, b};
            4'b1110: alu_data = {1'b0, a & ~b};
            4'b1111: alu_data = {1'b0, ~b};
            default: alu_data = 33'd0;
        endcase
    end

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          pre_reg;
        logic [31:0] pre_val;
        int          lat;
        bit          we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  nzcv;
        bit          ill;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(
        input logic [3:0] c, input logic i, input logic [3:0] op,
        input logic s, input logic [3:0] rn, input logic [3:0] rd,
        input logic [7:0] lo);
        return {c, 2'b00, i, op, s, rn, rd, 4'd0, lo};
    endfunction

    function automatic vec_t mkv(
        input string nm, input logic [31:0] ins, input int pr,
        input logic [31:0] pv, input int lat, input bit we,
        input logic [3:0] wa, input logic [31:0] wd,
        input logic [3:0] f, input bit ill);
        vec_t v;
        v.name = nm; v.ins = ins; v.pre_reg = pr; v.pre_val = pv;
        v.lat = lat; v.we = we; v.waddr = wa; v.wdata = wd;
        v.nzcv = f; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] val);
        @(negedge clk);
        tb_wr = 1'b1; tb_waddr = a; tb_wval = val;
        @(posedge clk);
        #1 tb_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input string nm, input logic [31:0] ins);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready_wait"}, {31'd0, instr_ready}, 32'd1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 32'd0;
    endtask

    task automatic run(input string nm, input logic [31:0] ins,
                       output int lat, output int wes,
                       output logic [3:0] wa, output logic [31:0] wd,
                       output logic ill, output logic rdy);
        issue(nm, ins);
        lat = 0; wes = 0; wa = 4'd0; wd = 32'd0; ill = 1'b0; rdy = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rf_we) begin
                wes++;
                wa = rf_waddr;
                wd = rf_wdata;
            end
            if (done) begin
                lat = k;
                ill = illegal;
                rdy = instr_ready;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int wes;
        logic [3:0] wa;
        logic [31:0] wd;
        logic ill;
        logic rdy;
        logic [31:0] r0_before;
        int we_seen;

        // reset state
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_nzcv", {28'd0, nzcv}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("rst_alu_r2", alu_r2, 32'd0);

        preload(4'd2, 32'd3);

        vq.push_back(mkv("adds_reg", mk(4'hE,0,4'b0100,1,4'd1,4'd0,8'h02),
            1, 32'd5, 5, 1, 4'd0, 32'd8, 4'b0000, 0));
        vq.push_back(mkv("cmp_imm_eq", mk(4'hE,1,4'b1010,1,4'd1,4'd0,8'h03),
            1, 32'd3, 4, 0, 4'd0, 32'd0, 4'b0110, 0));
        vq.push_back(mkv("movne_fail", mk(4'h1,1,4'b1101,0,4'd0,4'd4,8'h07),
            -1, 32'd0, 2, 0, 4'd0, 32'd0, 4'b0110, 0));
        vq.push_back(mkv("moveq_pass", mk(4'h0,1,4'b1101,0,4'd0,4'd4,8'h07),
            -1, 32'd0, 4, 1, 4'd4, 32'd7, 4'b0110, 0));
        vq.push_back(mkv("adds_ovf", mk(4'hE,1,4'b0100,1,4'd1,4'd0,8'h01),
            1, 32'h7FFFFFFF, 4, 1, 4'd0, 32'h80000000, 4'b1001, 0));
        vq.push_back(mkv("illegal_0011", mk(4'hE,0,4'b0011,1,4'd1,4'd0,8'h02),
            -1, 32'd0, 2, 0, 4'd0, 32'd0, 4'b1001, 1));
        vq.push_back(mkv("subs_reg", mk(4'hE,0,4'b0010,1,4'd1,4'd3,8'h02),
            -1, 32'd0, 5, 1, 4'd3, 32'h7FFFFFFC, 4'b0010, 0));
        vq.push_back(mkv("movgt_pass", mk(4'hC,1,4'b1101,0,4'd0,4'd5,8'h11),
            -1, 32'd0, 4, 1, 4'd5, 32'h11, 4'b0010, 0));
        vq.push_back(mkv("bics_zero", mk(4'hE,0,4'b1110,1,4'd2,4'd6,8'h02),
            -1, 32'd0, 5, 1, 4'd6, 32'd0, 4'b0110, 0));
        vq.push_back(mkv("nv_fail", mk(4'hF,1,4'b1101,0,4'd0,4'd7,8'h01),
            -1, 32'd0, 2, 0, 4'd0, 32'd0, 4'b0110, 0));
        vq.push_back(mkv("tst_imm", mk(4'hE,1,4'b1000,1,4'd1,4'd0,8'h80),
            -1, 32'd0, 4, 0, 4'd0, 32'd0, 4'b0010, 0));
        vq.push_back(mkv("ls_fail", mk(4'h9,1,4'b1101,0,4'd0,4'd7,8'h02),
            -1, 32'd0, 2, 0, 4'd0, 32'd0, 4'b0010, 0));
        vq.push_back(mkv("illegal_condfail", mk(4'h0,0,4'b0111,1,4'd1,4'd0,8'h02),
            -1, 32'd0, 2, 0, 4'd0, 32'd0, 4'b0010, 0));
        vq.push_back(mkv("cmp_reg_borrow", mk(4'hE,0,4'b1010,1,4'd2,4'd0,8'h05),
            -1, 32'd0, 5, 0, 4'd0, 32'd0, 4'b1000, 0));
        vq.push_back(mkv("movlt_pass", mk(4'hB,1,4'b1101,0,4'd0,4'd8,8'h5A),
            -1, 32'd0, 4, 1, 4'd8, 32'h5A, 4'b1000, 0));
        vq.push_back(mkv("eors_imm", mk(4'hE,1,4'b0001,1,4'd1,4'd9,8'hFF),
            -1, 32'd0, 4, 1, 4'd9, 32'h7FFFFF00, 4'b0000, 0));
        vq.push_back(mkv("mvns_reg", mk(4'hE,0,4'b1111,1,4'd0,4'd7,8'h02),
            -1, 32'd0, 5, 1, 4'd7, 32'hFFFFFFFC, 4'b1000, 0));
        vq.push_back(mkv("adds_carry", mk(4'hE,0,4'b0100,1,4'd7,4'd10,8'h07),
            -1, 32'd0, 5, 1, 4'd10, 32'hFFFFFFF8, 4'b1010, 0));

        foreach (vq[i]) begin
            if (vq[i].pre_reg >= 0)
                preload(vq[i].pre_reg[3:0], vq[i].pre_val);
            run(vq[i].name, vq[i].ins, lat, wes, wa, wd, ill, rdy);
            chk({vq[i].name, "_latency"}, lat, vq[i].lat);
            chk({vq[i].name, "_we_count"}, wes, vq[i].we ? 1 : 0);
            if (vq[i].we) begin
                chk({vq[i].name, "_waddr"}, {28'd0, wa}, {28'd0, vq[i].waddr});
                chk({vq[i].name, "_wdata"}, wd, vq[i].wdata);
            end
            chk({vq[i].name, "_nzcv"}, {28'd0, nzcv}, {28'd0, vq[i].nzcv});
            chk({vq[i].name, "_illegal"}, {31'd0, ill}, {31'd0, vq[i].ill});
            chk({vq[i].name, "_ready_at_done"}, {31'd0, rdy}, 32'd0);
            @(negedge clk);
            chk({vq[i].name, "_done_pulse"}, {30'd0, done, rf_we}, 32'd0);
        end

        // abort an ADDS in EXEC with an asynchronous reset
        r0_before = rf[0];
        issue("abort", mk(4'hE,0,4'b0100,1,4'd7,4'd0,8'h07));
        repeat (4) @(negedge clk);
        chk("abort_in_exec", {28'd0, alu_opcode}, 32'h4);
        rst_n = 1'b0;
        #1;
        chk("abort_nzcv", {28'd0, nzcv}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        we_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rf_we) we_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rf_we) we_seen++;
        chk("abort_no_we", we_seen, 0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_nzcv_after", {28'd0, nzcv}, 32'd0);
        chk("abort_r0_kept", rf[0], r0_before);

        run("post_reset_mov", mk(4'hE,1,4'b1101,0,4'd0,4'd11,8'h33),
            lat, wes, wa, wd, ill, rdy);
        chk("post_reset_latency", lat, 4);
        chk("post_reset_wdata", wd, 32'h33);
        chk("post_reset_waddr", {28'd0, wa}, 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
